tick_delay_arbiter: RTL and testbench

- Shares one tick-driven delay engine among NREQ requesters. The tick source is the 1 s single-cycle enable from the prescaler counter.
- Each requester asks for a delay of D ticks. The block grants requesters one at a time in round-robin order, counts D ticks for the granted requester, then pulses that requester's done.
- Sits between the 1 s prescaler and the control FSMs that need timed waits.

---
 rtl/tick_delay_arbiter.sv | 133 +++++++++++++
 tb/tb_tick_delay_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_delay_arbiter.sv
// Round-robin arbiter in front of one shared tick-driven delay engine.
// A granted requester gets its delay counted down on tick, then a single done pulse.
//
// state | meaning
// IDLE  | engine free; arbitrate among req on the next edge
// RUN   | engine owned by cur_id; remaining counts down on tick
// DONE  | one-cycle done pulse to cur_id, engine released next edge
module tick_delay_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 2
) (
   input  logic                mclk,
   input  logic                reset,
   input  logic                tick,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*DW-1:0]  dly,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic                busy,
   output logic [IDW-1:0]      cur_id,
   output logic [DW-1:0]       remaining
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IDW-1:0]  last, last_nxt, cur_id_nxt, sel;
   logic [NREQ-1:0] gnt_nxt, done_nxt, sel_oh;
   logic [DW-1:0]   rem_nxt, sel_dly;
   logic            busy_nxt, sel_found, owner_req;

   // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      sel_found = 1'b0;
      sel       = '0;
      sel_oh    = '0;
      sel_dly   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req[i]) begin
            sel_found = 1'b1;
            sel       = IDW'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_dly   = dly[i*DW +: DW];
         end
      end
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req[i] && (i > int'(last))) begin
            sel       = IDW'(i);
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_dly   = dly[i*DW +: DW];
         end
      end
   end

   // gnt is one-hot on cur_id throughout RUN, so this is req[cur_id].
   assign owner_req = |(req & gnt);

   always_comb begin
      state_nxt  = state;
      gnt_nxt    = gnt;
      done_nxt   = '0;
      busy_nxt   = busy;
      cur_id_nxt = cur_id;
      rem_nxt    = remaining;
      last_nxt   = last;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt  = RUN;
               gnt_nxt    = sel_oh;
               cur_id_nxt = sel;
               rem_nxt    = sel_dly;
               busy_nxt   = 1'b1;
            end
         end
         RUN: begin
            if (!owner_req) begin
               state_nxt  = IDLE;
               gnt_nxt    = '0;
               busy_nxt   = 1'b0;
               cur_id_nxt = '0;
               rem_nxt    = '0;
               last_nxt   = cur_id;
            end else if ((remaining == '0) || (tick && (remaining == DW'(1)))) begin
               // A zero delay finishes after its single grant cycle without a tick.
               state_nxt = DONE;
               gnt_nxt   = '0;
               done_nxt  = gnt;
               rem_nxt   = '0;
            end else if (tick) begin
               rem_nxt = remaining - DW'(1);
            end
         end
         DONE: begin
            state_nxt  = IDLE;
            busy_nxt   = 1'b0;
            cur_id_nxt = '0;
            last_nxt   = cur_id;
         end
         default: begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            busy_nxt   = 1'b0;
            cur_id_nxt = '0;
            rem_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= '0;
         done      <= '0;
         busy      <= 1'b0;
         cur_id    <= '0;
         remaining <= '0;
         last      <= IDW'(NREQ-1);
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         cur_id    <= cur_id_nxt;
         remaining <= rem_nxt;
         last      <= last_nxt;
      end
   end

endmodule

// File: tb/tb_tick_delay_arbiter.sv
// Bench for tick_delay_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against an ownership/countdown model.
module tb_tick_delay_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic                mclk  = 1'b0;
   logic                reset = 1'b0;
   logic                tick  = 1'b0;
   logic [NREQ-1:0]     req   = '0;
   logic [NREQ*DW-1:0]  dly   = '0;
   logic [NREQ-1:0]     gnt, done;
   logic                busy;
   logic [IDW-1:0]      cur_id;
   logic [DW-1:0]       remaining;

   int n_checks = 0;
   int n_fail   = 0;

   tick_delay_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
      .mclk(mclk), .reset(reset), .tick(tick), .req(req), .dly(dly),
      .gnt(gnt), .done(done), .busy(busy), .cur_id(cur_id), .remaining(remaining)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_dly(input int i, input int v);
      dly[i*DW +: DW] = DW'(v);
   endtask

   // Model: who owns the engine, how many ticks are left, and whether the
   // owner is in its done cycle. owner = -1 means the engine is free.
   int m_owner = -1;
   int m_left  = 0;
   int m_last  = NREQ-1;
   bit m_fin   = 1'b0;

   always @(posedge mclk or negedge reset) begin
      if (!reset) begin
         m_owner = -1; m_left = 0; m_last = NREQ-1; m_fin = 1'b0;
      end else if (m_fin) begin
         m_last = m_owner; m_owner = -1; m_fin = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            if (m_owner < 0 && req[(m_last + k) % NREQ]) begin
               m_owner = (m_last + k) % NREQ;
               m_left  = int'(dly[m_owner*DW +: DW]);
            end
         end
      end else if (!req[m_owner]) begin
         m_last = m_owner; m_owner = -1; m_left = 0;
      end else if (m_left == 0) begin
         m_fin = 1'b1;
      end else if (tick) begin
         m_left--;
         if (m_left == 0) m_fin = 1'b1;
      end
   end

   always @(negedge mclk) begin
      logic [NREQ-1:0] e_gnt, e_done;
      e_gnt  = '0;
      e_done = '0;
      if (m_owner >= 0) begin
         if (m_fin) e_done[m_owner] = 1'b1;
         else       e_gnt[m_owner]  = 1'b1;
      end
      chk("model_gnt",  gnt,  e_gnt);
      chk("model_done", done, e_done);
      chk("model_busy", busy, (m_owner >= 0) ? 1 : 0);
      chk("model_id",   cur_id, (m_owner >= 0) ? m_owner : 0);
      chk("model_rem",  remaining, (m_owner >= 0 && !m_fin) ? m_left : 0);
   end

   initial begin
      repeat (2) @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rem", remaining, 0);

      // single request, delay 3, tick every 5 cycles
      req = 4'b0001; set_dly(0, 3);
      @(negedge mclk);
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_rem", remaining, 3);
      for (int t = 0; t < 3; t++) begin
         repeat (4) @(negedge mclk);
         tick = 1'b1;
         @(negedge mclk);
         tick = 1'b0;
         if (t < 2) chk("t1_rem_step", remaining, 2 - t);
      end
      chk("t1_done", done, 4'b0001);
      chk("t1_gnt_off", gnt, 0);
      chk("t1_busy_done", busy, 1);
      req = '0;
      @(negedge mclk);
      chk("t1_done_off", done, 0);
      chk("t1_busy_off", busy, 0);

      // zero delay
      req = 4'b0100; set_dly(2, 0);
      @(negedge mclk);
      chk("z_gnt", gnt, 4'b0100);
      chk("z_rem", remaining, 0);
      @(negedge mclk);
      chk("z_done", done, 4'b0100);
      chk("z_gnt_off", gnt, 0);
      req = '0;
      @(negedge mclk);
      chk("z_done_off", done, 0);

      // round robin after a fresh reset
      reset = 1'b0;
      @(negedge mclk);
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) set_dly(i, 1);
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         @(negedge mclk);
         chk("rr_gnt", gnt, 4'b0001 << (g % 4));
         tick = 1'b1;
         @(negedge mclk);
         tick = 1'b0;
         chk("rr_done", done, 4'b0001 << (g % 4));
         if (g == 4) req = '0;
         @(negedge mclk);
         chk("rr_idle_busy", busy, 0);
         chk("rr_idle_gnt", gnt, 0);
      end

      // abort, then tick on grant capture, then final tick coinciding with drop
      req = 4'b0110; set_dly(1, 10); set_dly(2, 2);
      @(negedge mclk);
      chk("ab_gnt", gnt, 4'b0010);
      chk("ab_rem", remaining, 10);
      tick = 1'b1; @(negedge mclk); tick = 1'b0; @(negedge mclk);
      tick = 1'b1; @(negedge mclk); tick = 1'b0;
      chk("ab_rem8", remaining, 8);
      req = 4'b0100;
      @(negedge mclk);
      chk("ab_gnt_off", gnt, 0);
      chk("ab_no_done", done, 0);
      chk("ab_rem0", remaining, 0);
      tick = 1'b1;
      @(negedge mclk);
      tick = 1'b0;
      chk("ab_next_gnt", gnt, 4'b0100);
      chk("cap_tick_ignored", remaining, 2);
      tick = 1'b1; @(negedge mclk); tick = 1'b0;
      chk("sim_rem1", remaining, 1);
      tick = 1'b1; req = '0;
      @(negedge mclk);
      tick = 1'b0;
      chk("sim_gnt_off", gnt, 0);
      chk("sim_no_done", done, 0);
      chk("sim_busy_off", busy, 0);
      @(negedge mclk);
      chk("sim_no_done_late", done, 0);

      // async reset mid-run
      req = 4'b0001; set_dly(0, 5);
      @(negedge mclk);
      chk("ar_rem", remaining, 5);
      #2 reset = 1'b0;
      #1;
      chk("ar_gnt", gnt, 0);
      chk("ar_busy", busy, 0);
      chk("ar_rem0", remaining, 0);
      req = 4'b1001;
      repeat (2) @(negedge mclk);
      reset = 1'b1;
      @(negedge mclk);
      chk("ar_first", gnt, 4'b0001);
      req = '0;
      @(negedge mclk);

      // random traffic, checked by the per-cycle model compare
      for (int c = 0; c < 4000; c++) begin
         @(negedge mclk);
         tick = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 24) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 3) == 0) dly[i*DW +: DW] = DW'($urandom_range(0, 5));
         end
      end
      req = '0; tick = 1'b0;
      repeat (5) @(negedge mclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
